// File: rtl/phase_delay_pkg.sv
// Shared constants for the phase-delay programming line: frame layout, parity and FSM encoding.
// Build option: PHASE_PARITY_EN appends an even-parity bit after the phase LSB.
package phase_delay_pkg;

    localparam int NUM_SIZE = 7;
    localparam int HDR_SIZE = 4;
    localparam logic [HDR_SIZE-1:0] HEADER = 4'b0100;

`ifdef PHASE_PARITY_EN
    localparam int PAR_SIZE = 1;
`else
    localparam int PAR_SIZE = 0;
`endif

    localparam int SEQ_SIZE = HDR_SIZE + NUM_SIZE + PAR_SIZE;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    // Word as it goes out on the line, MSB first; the decoder rebuilds the same layout.
    function automatic logic [SEQ_SIZE-1:0] frameWord(input logic [NUM_SIZE-1:0] phase);
`ifdef PHASE_PARITY_EN
        return {HEADER, phase, ^{HEADER, phase}};
`else
        return {HEADER, phase};
`endif
    endfunction

endpackage

// File: rtl/phase_word_encoder_if.sv
// Start/ready request side and serial line outputs of the phase word encoder.
interface phase_word_encoder_if;
    import phase_delay_pkg::*;

    logic                start;
    logic [NUM_SIZE-1:0] phase_in;
    logic                ready;
    logic                ser_out;
    logic                frame_active;
    logic                done;

    modport master (
        output start, phase_in,
        input  ready, ser_out, frame_active, done
    );

    modport slave (
        input  start, phase_in,
        output ready, ser_out, frame_active, done
    );

endinterface

// File: rtl/phase_word_encoder_bit_timer.sv
// BIT_CLKS divider: one-cycle tick on the last clock of each bit period while enabled.
module bit_timer #(
    parameter int BIT_CLKS = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    logic [CW-1:0] clkCnt;

    assign tick = en && (clkCnt == CW'(BIT_CLKS - 1));

    // Held at zero while disabled so every enable starts a full bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clkCnt <= '0;
        else if (!en || tick)
            clkCnt <= '0;
        else
            clkCnt <= clkCnt + 1'b1;
    end

endmodule

// File: rtl/phase_word_encoder.sv
// Serial transmitter for the phase-delay line: {HEADER, phase} MSB first, BIT_CLKS per bit, low gap.
// Build option: PHASE_PARITY_EN (frame layout lives in phase_delay_pkg).
module phase_word_encoder
    import phase_delay_pkg::*;
#(
    parameter int BIT_CLKS = 1024,
    parameter int GAP_BITS = 2
) (
    input logic           clk,
    input logic           rst_n,
    phase_word_encoder_if.slave bus
);
    localparam int BW = (SEQ_SIZE > 1) ? $clog2(SEQ_SIZE) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    logic [1:0]          state;
    logic [SEQ_SIZE-1:0] shiftReg;
    logic [BW-1:0]       bitCnt;
    logic [GW-1:0]       gapCnt;
    logic                doneReg;
    logic                timerEn;
    logic                tick;

    assign timerEn = (state != IDLE);

    bit_timer #(.BIT_CLKS(BIT_CLKS)) uTimer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (timerEn),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
            gapCnt   <= '0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shiftReg <= frameWord(bus.phase_in);
                        bitCnt   <= BW'(SEQ_SIZE - 1);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (bitCnt == '0) begin
                            // Line is driven from the register MSB, so clearing it drops the line.
                            shiftReg <= '0;
                            gapCnt   <= '0;
                            state    <= GAP;
                        end else begin
                            shiftReg <= shiftReg << 1;
                            bitCnt   <= bitCnt - 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gapCnt == GW'(GAP_BITS - 1)) begin
                            doneReg <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            gapCnt <= gapCnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready        = (state == IDLE);
    assign bus.ser_out      = shiftReg[SEQ_SIZE-1];
    assign bus.frame_active = (state == SHIFT);
    assign bus.done         = doneReg;

endmodule
